// File: rtl/piccolo_round_ctrl.sv
// Piccolo-128 round sequencer: intake, pre-whitening, RPC-round scheduling, final permutation and post-whitening.
// Optional abort input enabled by defining PICCOLO_CTRL_ABORT_EN.
module piccolo_round_ctrl #(
  parameter int ROUNDS = 31,
  parameter int RPC    = 4,
  parameter int IDXW   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [0:63]                plaintext,
  input  logic [0:127]               keyin,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef PICCOLO_CTRL_ABORT_EN
  input  logic                       abort,
`endif
  output logic [0:63]                ciphertext,
  output logic [0:63]                rnd_data_o,
  output logic [0:127]               rnd_key_o,
  output logic [IDXW-1:0]            rnd_idx,
  output logic [$clog2(RPC+1)-1:0]   rnd_num,
  input  logic [0:63]                rnd_data_i,
  input  logic [0:127]               rnd_key_i
);

  localparam int NW = $clog2(RPC+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [0:63]     d;
  logic [0:127]    rk;
  logic [0:31]     mk;
  logic [IDXW:0]   remain;
  logic            last_run;
  logic            abort_hit;
  logic [0:63]     final_ct;

`ifdef PICCOLO_CTRL_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Only the post-whitening bytes of the master key are retained:
  // mk = {k[64:71], k[72:79], k[112:119], k[120:127]}.
  assign remain     = (IDXW+1)'(ROUNDS + 1) - {1'b0, rnd_idx};
  assign last_run   = (state == RUN) && (remain <= (IDXW+1)'(RPC));
  assign rnd_data_o = d;
  assign rnd_key_o  = rk;
  assign final_ct   = {{rnd_data_i[48:55], rnd_data_i[24:31]} ^ {mk[0:7], mk[24:31]},
                       rnd_data_i[0:7], rnd_data_i[40:47],
                       {rnd_data_i[16:23], rnd_data_i[56:63]} ^ {mk[16:23], mk[8:15]},
                       rnd_data_i[32:39], rnd_data_i[8:15]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN: begin
        if (abort_hit)     state_next = IDLE;
        else if (last_run) state_next = DONE;
      end
      DONE: begin
        if (abort_hit || out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    rnd_num   = '0;
    if (state == RUN) begin
      if (remain <= (IDXW+1)'(RPC)) rnd_num = NW'(remain);
      else                          rnd_num = NW'(RPC);
    end
  end

  // rnd_idx returns to 1 on the completing edge so it never reaches ROUNDS+1
  // and cannot wrap when ROUNDS == 2**IDXW-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d          <= '0;
      rk         <= '0;
      mk         <= '0;
      ciphertext <= '0;
      rnd_idx    <= IDXW'(1);
    end else if (abort_hit) begin
      d       <= '0;
      rk      <= '0;
      mk      <= '0;
      rnd_idx <= IDXW'(1);
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d       <= {plaintext[0:15] ^ {keyin[0:7], keyin[24:31]}, plaintext[16:31],
                        plaintext[32:47] ^ {keyin[16:23], keyin[8:15]}, plaintext[48:63]};
            rk      <= {keyin[32:127], keyin[0:31]};
            mk      <= {keyin[64:79], keyin[112:127]};
            rnd_idx <= IDXW'(1);
          end
        end
        RUN: begin
          d  <= rnd_data_i;
          rk <= rnd_key_i;
          if (last_run) begin
            ciphertext <= final_ct;
            rnd_idx    <= IDXW'(1);
          end else begin
            rnd_idx <= rnd_idx + IDXW'(rnd_num);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piccolo_round_ctrl.sv
// Directed self-checking bench for piccolo_round_ctrl with a datapath stub (identity or scrambling).
// Define PICCOLO_CTRL_ABORT_EN to also exercise the abort input.
module tb_piccolo_round_ctrl;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [0:63]   plaintext;
  logic [0:127]  keyin;
  logic          out_valid;
  logic          out_ready;
  logic          abort;
  logic [0:63]   ciphertext;
  logic [0:63]   rnd_data_o;
  logic [0:127]  rnd_key_o;
  logic [4:0]    rnd_idx;
  logic [2:0]    rnd_num;
  logic [0:63]   rnd_data_i;
  logic [0:127]  rnd_key_i;
  bit            stub_mode;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [0:127] KEY = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  piccolo_round_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .keyin(keyin), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PICCOLO_CTRL_ABORT_EN
    .abort(abort),
`endif
    .ciphertext(ciphertext), .rnd_data_o(rnd_data_o), .rnd_key_o(rnd_key_o),
    .rnd_idx(rnd_idx), .rnd_num(rnd_num), .rnd_data_i(rnd_data_i), .rnd_key_i(rnd_key_i)
  );

  // Scrambling stub: byte-rotate state and key, fold in the round index/count.
  always_comb begin
    rnd_data_i = rnd_data_o;
    rnd_key_i  = rnd_key_o;
    if (stub_mode) begin
      rnd_data_i = {rnd_data_o[8:63], rnd_data_o[0:7]} ^ {51'b0, rnd_idx, 5'b0, rnd_num};
      rnd_key_i  = {rnd_key_o[8:127], rnd_key_o[0:7]};
    end
  end

  function automatic logic [0:63] ref_ct(input logic [0:63] pt, input logic [0:127] k, input bit mode);
    logic [0:63] s;
    int idx, n;
    s = {pt[0:15] ^ {k[0:7], k[24:31]}, pt[16:31], pt[32:47] ^ {k[16:23], k[8:15]}, pt[48:63]};
    idx = 1;
    while (idx <= 31) begin
      n = (32 - idx < 4) ? 32 - idx : 4;
      if (mode) s = {s[8:63], s[0:7]} ^ {51'b0, 5'(idx), 5'b0, 3'(n)};
      idx += n;
    end
    return {{s[48:55], s[24:31]} ^ {k[64:71], k[120:127]}, s[0:7], s[40:47],
            {s[16:23], s[56:63]} ^ {k[112:119], k[72:79]}, s[32:39], s[8:15]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [0:63] pt, input logic [0:127] k);
    plaintext = pt;
    keyin     = k;
    in_valid  = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    step;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: out_valid=%b required 1 within 20 cycles", name, out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ciphertext !== 64'h0 ||
        rnd_idx !== 5'd1 || rnd_num !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b ct=%h idx=%0d num=%0d required 1 0 0 1 0",
               in_ready, out_valid, ciphertext, rnd_idx, rnd_num);
    end
    @(negedge clk);
    reset = 1'b1;
    step;
  endtask

  task automatic test_identity;
    accept(64'h0, KEY);
    vectors++;
    if (rnd_data_o !== 64'h0033000022110000 || rnd_key_o !== 128'h445566778899aabbccddeeff00112233) begin
      miscompares++;
      $display("[TB] FAIL prewhiten: d=%h rk=%h required 0033000022110000 445566778899aabbccddeeff00112233",
               rnd_data_o, rnd_key_o);
    end
    for (int j = 1; j <= 8; j++) begin
      vectors++;
      if (rnd_idx !== 5'(1 + 4*(j-1)) || rnd_num !== ((j < 8) ? 3'd4 : 3'd3) || out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL trace_%0d: idx=%0d num=%0d valid=%b required %0d %0d 0",
                 j, rnd_idx, rnd_num, out_valid, 1 + 4*(j-1), (j < 8) ? 4 : 3);
      end
      step;
    end
    vectors++;
    if (out_valid !== 1'b1 || ciphertext !== 64'h88ff0011ee992233 || rnd_num !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL identity_ct: valid=%b ct=%h num=%0d required 1 88ff0011ee992233 0",
               out_valid, ciphertext, rnd_num);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL identity_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_hold_back_to_back;
    logic [0:63] held;
    accept(64'h0, KEY);
    wait_out("hold");
    held = ciphertext;
    plaintext = 64'h0123456789abcdef;
    in_valid  = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ciphertext !== 64'h88ff0011ee992233) begin
        miscompares++;
        $display("[TB] FAIL hold_%0d: valid=%b ready=%b ct=%h required 1 0 88ff0011ee992233",
                 j, out_valid, in_ready, ciphertext);
      end
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ciphertext !== held) begin
      miscompares++;
      $display("[TB] FAIL hold_release: valid=%b ready=%b ct=%h required 0 1 %h",
               out_valid, in_ready, ciphertext, held);
    end
    step;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || rnd_num !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_accept: ready=%b num=%0d required 0 4", in_ready, rnd_num);
    end
    wait_out("b2b");
    vectors++;
    if (ciphertext !== 64'h459801baab76ab10) begin
      miscompares++;
      $display("[TB] FAIL b2b_ct: ct=%h required 459801baab76ab10", ciphertext);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask

  task automatic test_stub_datapath;
    logic [0:63] exp;
    stub_mode = 1'b1;
    exp = ref_ct(64'h0123456789abcdef, KEY, 1'b1);
    accept(64'h0123456789abcdef, KEY);
    step;
    vectors++;
    if (rnd_key_o !== 128'h5566778899aabbccddeeff0011223344) begin
      miscompares++;
      $display("[TB] FAIL stub_key_capture: rk=%h required 5566778899aabbccddeeff0011223344", rnd_key_o);
    end
    wait_out("stub");
    vectors++;
    if (ciphertext !== exp) begin
      miscompares++;
      $display("[TB] FAIL stub_ct: ct=%h required %h", ciphertext, exp);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    stub_mode = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    accept(64'h0, KEY);
    step;
    step;
    step;
    vectors++;
    if (rnd_idx !== 5'd13) begin
      miscompares++;
      $display("[TB] FAIL mid_run_idx: idx=%0d required 13", rnd_idx);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rnd_num !== 3'd0 || ciphertext !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_run_reset: valid=%b ready=%b num=%0d ct=%h required 0 1 0 0",
               out_valid, in_ready, rnd_num, ciphertext);
    end
    step;
    reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL post_reset_%0d: valid=%b ready=%b required 0 1", j, out_valid, in_ready);
      end
    end
  endtask

`ifdef PICCOLO_CTRL_ABORT_EN
  task automatic test_abort;
    accept(64'h0, KEY);
    step;
    step;
    abort = 1'b1;
    step;
    abort = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rnd_data_o !== 64'h0 || rnd_key_o !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL abort_state: valid=%b ready=%b d=%h rk=%h required 0 1 0 0",
               out_valid, in_ready, rnd_data_o, rnd_key_o);
    end
    for (int j = 0; j < 10; j++) begin
      step;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort_quiet_%0d: valid=%b required 0", j, out_valid);
      end
    end
    accept(64'h0123456789abcdef, KEY);
    wait_out("after_abort");
    vectors++;
    if (ciphertext !== 64'h459801baab76ab10) begin
      miscompares++;
      $display("[TB] FAIL after_abort_ct: ct=%h required 459801baab76ab10", ciphertext);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    abort     = 1'b0;
    plaintext = '0;
    keyin     = '0;
    stub_mode = 1'b0;
    test_reset;
    test_identity;
    test_hold_back_to_back;
    test_stub_datapath;
    test_reset_mid_run;
`ifdef PICCOLO_CTRL_ABORT_EN
    test_abort;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
